// File: rtl/line_buf_pkg.sv
// Shared defaults and helpers for the line window buffer.
// Contents: default geometry localparams and the tap slicing helper.
package line_buf_pkg;

  localparam int unsigned DEF_LINE_WIDTH = 320;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_LINES  = 3;

  // Bit offset of tap k inside the packed taps bus (tap0 in the low bits).
  function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned data_width);
    return k * data_width;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line memory: simple dual-port RAM with a registered read port.
// Ports:
//   clock, reset       - system clock, async active-high reset (read register only)
//   wr_en/addr/data    - write port
//   rd_en/addr         - read request, data appears on rd_data after the edge
//   rd_data            - registered read data, holds while rd_en is low
module line_ram
  import line_buf_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEF_LINE_WIDTH,
  parameter  int unsigned WIDTH  = DEF_DATA_WIDTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register; a same-address write in the same cycle is forwarded so the
  // reader always sees the newest value rather than the pre-write contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line pixel buffer: presents the current pixel plus the NUM_LINES-1
// column-aligned pixels above it, with column/row tracking and boundary flags.
// Ports:
//   clock, reset  - system clock, async active-high reset
//   data_in       - incoming pixel, accepted when data_valid is high
//   data_valid    - accept strobe
//   frame_start   - accepted pixel restarts at col 0 / row 0
//   taps_out      - packed column, tap0 = newest, tap k = k lines above
//   taps_valid    - taps_out holds a full column
//   line_valid    - taps_out was updated by an accept
//   col_index     - column of the pixel in taps_out
//   line_end      - taps_out holds the last column of a line
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter  int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned NUM_LINES  = DEF_NUM_LINES,
  localparam int unsigned COL_W      = $clog2(LINE_WIDTH)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            data_valid,
  input  logic                            frame_start,
  output logic [NUM_LINES*DATA_WIDTH-1:0] taps_out,
  output logic                            taps_valid,
  output logic                            line_valid,
  output logic [COL_W-1:0]                col_index,
  output logic                            line_end
);

  localparam int unsigned      ROW_W    = $clog2(NUM_LINES);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(NUM_LINES - 1);

  logic [COL_W-1:0]      col, col_eff, col_next;
  logic [ROW_W-1:0]      row, row_eff, row_next;
  logic [DATA_WIDTH-1:0] tap0;
  logic [DATA_WIDTH-1:0] tap [NUM_LINES];

  // Position of the pixel being accepted and the position of the one after it.
  always_comb begin
    col_eff  = frame_start ? '0 : col;
    row_eff  = frame_start ? '0 : row;
    col_next = col_eff + COL_W'(1);
    row_next = row_eff;
    if (col_eff == COL_LAST) begin
      col_next = '0;
      if (row_eff != ROW_SAT) begin
        row_next = row_eff + ROW_W'(1);
      end
    end
  end

  // Counters, newest pixel and qualifier flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      tap0       <= '0;
      col_index  <= '0;
      line_valid <= 1'b0;
      taps_valid <= 1'b0;
      line_end   <= 1'b0;
    end else if (data_valid) begin
      col        <= col_next;
      row        <= row_next;
      tap0       <= data_in;
      col_index  <= col_eff;
      line_valid <= 1'b1;
      taps_valid <= (row_eff == ROW_SAT);
      line_end   <= (col_eff == COL_LAST);
    end else begin
      line_valid <= 1'b0;
      taps_valid <= 1'b0;
      line_end   <= 1'b0;
    end
  end

  assign tap[0] = tap0;

  // Line memories. Memory k is read at the accepted column; in the cycle after
  // an accept it is written at that same column (col_index) with tap k-1, so
  // each column's history shifts down one memory per accepted pixel.
  for (genvar k = 1; k < NUM_LINES; k++) begin : g_line
    line_ram #(
      .DEPTH (LINE_WIDTH),
      .WIDTH (DATA_WIDTH)
    ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (line_valid),
      .wr_addr (col_index),
      .wr_data (tap[k-1]),
      .rd_en   (data_valid),
      .rd_addr (col_eff),
      .rd_data (tap[k])
    );
  end

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_pack
    assign taps_out[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = tap[k];
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench: two instances (4x3 and 7x5 geometry) driven with
// directed and $urandom stimulus, compared against a per-column history model.
module tb_line_window_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [7:0]  a_data  = '0;
  logic        a_valid = 1'b0;
  logic        a_fs    = 1'b0;
  logic [23:0] a_taps;
  logic        a_tv, a_lv, a_le;
  logic [1:0]  a_col;

  logic [7:0]  b_data  = '0;
  logic        b_valid = 1'b0;
  logic        b_fs    = 1'b0;
  logic [39:0] b_taps;
  logic        b_tv, b_lv, b_le;
  logic [2:0]  b_col;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: next position and per-column pixel history.
  int          m_col [2];
  int          m_row [2];
  logic [7:0]  m_hist [2][8][8];
  logic [63:0] exp_taps [2];
  int          exp_col [2];
  bit          taps_known [2];

  always #5 clock = ~clock;

  line_window_buffer #(.LINE_WIDTH(4), .DATA_WIDTH(8), .NUM_LINES(3)) u_dut_a (
    .clock       (clock),
    .reset       (reset),
    .data_in     (a_data),
    .data_valid  (a_valid),
    .frame_start (a_fs),
    .taps_out    (a_taps),
    .taps_valid  (a_tv),
    .line_valid  (a_lv),
    .col_index   (a_col),
    .line_end    (a_le)
  );

  line_window_buffer #(.LINE_WIDTH(7), .DATA_WIDTH(8), .NUM_LINES(5)) u_dut_b (
    .clock       (clock),
    .reset       (reset),
    .data_in     (b_data),
    .data_valid  (b_valid),
    .frame_start (b_fs),
    .taps_out    (b_taps),
    .taps_valid  (b_tv),
    .line_valid  (b_lv),
    .col_index   (b_col),
    .line_end    (b_le)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus on instance sel, then compare against the model.
  task automatic step(input int sel, input bit v, input logic [7:0] pix, input bit fs);
    int nl, lw, c, r;
    bit e_lv, e_tv, e_le;
    logic [63:0] g_taps;
    logic [7:0]  g_col;
    bit g_lv, g_tv, g_le;
    nl = (sel == 0) ? 3 : 5;
    lw = (sel == 0) ? 4 : 7;
    e_lv = 1'b0; e_tv = 1'b0; e_le = 1'b0;
    if (v) begin
      c = fs ? 0 : m_col[sel];
      r = fs ? 0 : m_row[sel];
      e_lv = 1'b1;
      e_tv = (r == nl - 1);
      e_le = (c == lw - 1);
      exp_col[sel] = c;
      exp_taps[sel] = '0;
      exp_taps[sel][7:0] = pix;
      for (int k = 1; k < nl; k++) exp_taps[sel][k*8 +: 8] = m_hist[sel][c][k-1];
      for (int k = nl - 1; k > 0; k--) m_hist[sel][c][k] = m_hist[sel][c][k-1];
      m_hist[sel][c][0] = pix;
      taps_known[sel] = e_tv;
      if (c == lw - 1) begin
        m_col[sel] = 0;
        if (r < nl - 1) r++;
      end else begin
        m_col[sel] = c + 1;
      end
      m_row[sel] = r;
    end
    if (sel == 0) begin
      a_valid = v; a_data = pix; a_fs = fs; b_valid = 1'b0; b_fs = 1'b0;
    end else begin
      b_valid = v; b_data = pix; b_fs = fs; a_valid = 1'b0; a_fs = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    if (sel == 0) begin
      g_taps = 64'(a_taps); g_col = 8'(a_col); g_lv = a_lv; g_tv = a_tv; g_le = a_le;
    end else begin
      g_taps = 64'(b_taps); g_col = 8'(b_col); g_lv = b_lv; g_tv = b_tv; g_le = b_le;
    end
    check("line_valid", 64'(g_lv), 64'(e_lv));
    check("taps_valid", 64'(g_tv), 64'(e_tv));
    check("line_end",   64'(g_le), 64'(e_le));
    check("col_index",  64'(g_col), 64'(exp_col[sel]));
    if (taps_known[sel]) check("taps", g_taps, exp_taps[sel]);
    else                 check("tap0", 64'(g_taps[7:0]), 64'(exp_taps[sel][7:0]));
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; a_fs = 1'b0; b_fs = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_a_taps", 64'(a_taps), 64'h0);
    check("rst_a_flags", 64'({a_tv, a_lv, a_le}), 64'h0);
    check("rst_a_col", 64'(a_col), 64'h0);
    check("rst_b_taps", 64'(b_taps), 64'h0);
    check("rst_b_flags", 64'({b_tv, b_lv, b_le}), 64'h0);
    check("rst_b_col", 64'(b_col), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_col[s] = 0; m_row[s] = 0; exp_taps[s] = '0; exp_col[s] = 0; taps_known[s] = 1'b1;
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 8; c++)
        for (int k = 0; k < 8; k++) m_hist[s][c][k] = '0;
    @(negedge clock);
    do_reset();

    // Continuous frame, value = row*16+col, with directed boundary checks.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 1'b1, 8'(r*16 + c), (r == 0 && c == 0));
        if (r == 2 && c == 1) begin
          check("s1_taps", 64'(a_taps), 64'h011121);
          check("s1_tv", 64'(a_tv), 64'h1);
        end
        if (r == 1 && c == 3) check("s2_end", 64'({a_le, a_col}), 64'h7);
        if (r == 2 && c == 0) check("s2_wrap", 64'({a_le, a_col}), 64'h0);
      end
    end

    // Same frame, idle gaps between row-2 pixels (one gap carries a stray frame_start).
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(0, 1'b1, 8'(r*16 + c), (r == 0 && c == 0));
        if (r == 2) begin
          if (c == 1) check("s3_taps", 64'(a_taps), 64'h011121);
          for (int g = 0; g < 3; g++) step(0, 1'b0, 8'hEE, (g == 1));
        end
      end
    end

    // frame_start in the middle of row 2.
    for (int i = 0; i < 10; i++) step(0, 1'b1, 8'((i/4)*16 + i%4), (i == 0));
    step(0, 1'b1, 8'hA0, 1'b1);
    check("s4_col", 64'(a_col), 64'h0);
    check("s4_tv", 64'(a_tv), 64'h0);
    for (int i = 1; i < 14; i++) step(0, 1'b1, 8'(8'h40 + i), 1'b0);

    // Reset in the middle of row 2.
    for (int i = 0; i < 9; i++) step(0, 1'b1, 8'((i/4)*16 + i%4), (i == 0));
    do_reset();
    step(0, 1'b1, 8'h55, 1'b0);
    check("s5_col", 64'(a_col), 64'h0);
    check("s5_tv", 64'(a_tv), 64'h0);

    // Random traffic on the small instance.
    for (int i = 0; i < 300; i++)
      step(0, ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 39) == 0));

    // Wider geometry: 5 taps, 7 columns.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 7; c++) begin
        step(1, 1'b1, 8'(r*16 + c), (r == 0 && c == 0));
        if (r == 3 && c == 6) check("s6_tv_low", 64'(b_tv), 64'h0);
        if (r == 4 && c == 0) begin
          check("s6_tv_rise", 64'(b_tv), 64'h1);
          check("s6_tap4", 64'(b_taps[39:32]), 64'h00);
        end
        if (r == 4 && c == 3) check("s6_tap4_c3", 64'(b_taps[39:32]), 64'h03);
      end
    end
    for (int i = 0; i < 300; i++)
      step(1, ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 59) == 0));

    step(0, 1'b0, 8'h00, 1'b0);
    step(1, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
